// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the CPU user-input front end.
// Holds the capture FSM state encoding and the button/switch defaults.
package cpu_io_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    HOLD         = 2'd2,
    WAIT_RELEASE = 2'd3
  } cap_state_e;

  localparam int SW_WIDTH_DEF = 18;

  // The DE2 push-button is active-low, so the idle pin level reads high.
  localparam logic BTN_RELEASED = 1'b1;

  function automatic logic [31:0] zext_switches(input logic [31:0] sw_word);
    return sw_word;
  endfunction

endpackage

// File: rtl/input_capture_if.sv
// CPU-side valid/ack handshake carrying one captured switch word.
// The CPU is the master (request/ack); the capture block is the slave (valid/data).
interface input_capture_if;

  logic        input_req;
  logic        input_ack;
  logic        input_valid;
  logic [31:0] input_data;

  modport master (
    output input_req,
    output input_ack,
    input  input_valid,
    input  input_data
  );

  modport slave (
    input  input_req,
    input  input_ack,
    output input_valid,
    output input_data
  );

endinterface

// File: rtl/input_capture_debounce.sv
// Push-button synchronizer and debouncer with a one-cycle press strobe.
// Reusable for any active-low pushbutton (e.g. the reset button).
module debounce
  import cpu_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic button_raw_i,
  output logic stable_o,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   press_q, press_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchronizer chain; resets to the released level so no false press follows reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{BTN_RELEASED}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_raw_i};
    end
  end

  // Counter runs only while the synchronized level disagrees with the stable one.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (sync_s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d    = '0;
      stable_d = sync_s;
      press_d  = (sync_s != BTN_RELEASED);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= BTN_RELEASED;
      press_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;

endmodule

// File: rtl/input_capture.sv
// User-input front end: debounced button, synchronized switches and a
// capture FSM presenting one switch word per press over a valid/ack handshake.
module input_capture
  import cpu_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter int SW_WIDTH        = SW_WIDTH_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                button_raw,
  input  logic [SW_WIDTH-1:0] switches_raw,
  input_capture_if.slave      bus,
  output logic                button_pulse,
  output logic                busy
);

  logic                stable_s;
  logic                press_s;
  logic [SW_WIDTH-1:0] sw_sync_q [SYNC_STAGES];
  logic [SW_WIDTH-1:0] sw_sync_s;

  cap_state_e  state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic        pulse_q;
  logic        busy_q;

  debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_debounce (
    .clock        (clock),
    .reset        (reset),
    .button_raw_i (button_raw),
    .stable_o     (stable_s),
    .press_o      (press_s)
  );

  // Switches are only synchronized; they are sampled solely on a press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync_q[i] <= '0;
      end
    end else begin
      sw_sync_q[0] <= switches_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync_q[i] <= sw_sync_q[i-1];
      end
    end
  end

  assign sw_sync_s = sw_sync_q[SYNC_STAGES-1];

  // Capture FSM next-state and output-register inputs.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (bus.input_req) begin
          state_d = WAIT_PRESS;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_PRESS: begin
        // A request dropped in the same cycle as the press wins over the press.
        if (!bus.input_req) begin
          state_d = IDLE;
        end else if (press_s) begin
          state_d = HOLD;
          valid_d = 1'b1;
          data_d  = zext_switches(32'(sw_sync_s));
        end else begin
          state_d = WAIT_PRESS;
        end
      end
      HOLD: begin
        if (bus.input_ack) begin
          state_d = WAIT_RELEASE;
          valid_d = 1'b0;
        end else begin
          state_d = HOLD;
        end
      end
      WAIT_RELEASE: begin
        valid_d = 1'b0;
        if (stable_s == BTN_RELEASED) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_RELEASE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; busy tracks the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= 32'h0000_0000;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      pulse_q <= press_s;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.input_valid = valid_q;
  assign bus.input_data  = data_q;
  assign button_pulse    = pulse_q;
  assign busy            = busy_q;

endmodule

// File: doc/input_capture.md
# input_capture

Debounced, handshaked front end for the CPU's user-input path. It synchronizes the DE2 push-button and the 18 slide switches, debounces the button, and, when the CPU raises an input request, captures the switch word on a clean press. It then presents that word to the register-write mux through a valid/ack handshake. It sits directly upstream of the CPU top's `button`/`switches` inputs, replacing the raw pin connection.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles (10 ms at 50 MHz) required to accept a button level change; must be ≥ 2.
- `SYNC_STAGES`, default 2: synchronizer depth for button and switches; must be ≥ 2.
- `SW_WIDTH`, default 18: switch bus width; must be ≤ 32.
- `clock` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `button_raw` in 1: raw push-button pin, active-low (0 = pressed).
- `switches_raw` in SW_WIDTH: raw slide switches, asynchronous.
- `input_req` in 1: CPU is executing an input instruction and is stalled waiting for data; level.
- `input_ack` in 1: CPU has written `input_data` to its register file; single-cycle pulse.
- `input_valid` out 1: `input_data` holds a captured word.
- `input_data` out 32: captured switches, zero-extended to 32 bits.
- `button_pulse` out 1: one-cycle pulse per debounced press, independent of the handshake.
- `busy` out 1: FSM not in IDLE.

## Operation
- Synchronizer: `SYNC_STAGES` flops on `button_raw` and on each switch bit. Switches are synchronized only, not debounced; they are sampled solely at a press event.
- Debouncer: holds a stable level (reset: released) and a counter of width clog2(`DEBOUNCE_CYCLES`).
  - When the synchronized level equals the stable level, the counter clears.
  - Otherwise the counter increments. On reaching `DEBOUNCE_CYCLES`−1, the stable level flips and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes the stable level.
- Press event: a stable-level transition from released to pressed. The debouncer outputs it as a one-cycle `press` strobe.
- FSM states:
  - IDLE: `input_valid`=0. Goes to WAIT_PRESS when `input_req`=1.
  - WAIT_PRESS: waits for `press`.
    - On `press`: capture the synchronized switches into `input_data`, set `input_valid`=1, go to HOLD.
    - If `input_req` falls first: return to IDLE with no capture.
    - `input_req` falling in the same cycle as `press` counts as a drop; there is no capture.
  - HOLD: `input_valid`=1 and `input_data` frozen.
    - On `input_ack`: clear `input_valid`, go to WAIT_RELEASE.
    - `input_req` falling in HOLD is ignored; only `input_ack` leaves HOLD.
  - WAIT_RELEASE: waits until the debounced level is released, then goes to IDLE. A single press therefore never satisfies two consecutive input instructions.
- Presses in IDLE, HOLD or WAIT_RELEASE pulse `button_pulse` but capture nothing.
- `input_data`[31:SW_WIDTH] is always 0. `input_data` keeps its last captured value outside HOLD.

## Timing
- Reset values:
  - `input_valid`=0, `input_data`=0, `button_pulse`=0, `busy`=0.
  - FSM=IDLE, debounce counter=0, stable level=released.
  - Synchronizer flops=1 for the button and 0 for the switches.
- Reset asserted mid-handshake returns everything to the reset values immediately. There is no pending capture after release of reset.
- Press latency: take `button_raw` low and held, first sampled at edge E0.
  - The synchronized level changes at E0+SYNC_STAGES−1.
  - The stable level flips at E0+SYNC_STAGES−1+DEBOUNCE_CYCLES.
  - `button_pulse`, and (if in WAIT_PRESS) `input_valid`, go high after the next edge.
- `input_data` captures the switch value present at the synchronizer output in the same cycle `press` is high.
- `input_ack` sampled high in HOLD: `input_valid` is low after that same edge. The FSM then spends at least one cycle in WAIT_RELEASE.
- `input_ack` outside HOLD is ignored.
- `busy` is registered and equals (state != IDLE).

## Structure
- Shared package `cpu_io_pkg` contains:
  - the FSM state enum (IDLE, WAIT_PRESS, HOLD, WAIT_RELEASE);
  - the `SW_WIDTH` default constant;
  - the button-released level constant (1'b1).
- One sub-module, `debounce`, holds the synchronizer, counter, stable level and `press` strobe. It is parameterized by `DEBOUNCE_CYCLES` and `SYNC_STAGES` and is reused for the reset pushbutton later.
- The top of `input_capture` holds the switch synchronizer, the FSM and the output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `SYNC_STAGES`=2.
- Basic capture: raise `input_req`, set switches=18'h2A5C3, hold the button low for 10 cycles → `input_valid`=1 and `input_data`=32'h0002A5C3 exactly 6 edges after the first sampled low. `button_pulse` is high for one cycle.
- Glitch rejection: in WAIT_PRESS, apply button-low bursts of 1, 2 and 3 cycles → no `button_pulse`, `input_valid` stays 0, state stays WAIT_PRESS.
- Handshake and release: while in HOLD, pulse `input_ack` → `input_valid`=0 next cycle and `busy`=1. Hold the button pressed 20 cycles with `input_req` re-asserted → no second capture. After a clean release, a fresh press captures again.
- Request drop: raise `input_req`, drop it after 2 cycles, then press → `button_pulse` fires, `input_valid` stays 0, `busy`=0.
- Switch change after capture: capture 18'h00001, change switches to 18'h3FFFF during HOLD → `input_data` stays 32'h00000001 until the next capture.
- Async reset in HOLD: assert `reset` between edges → `input_valid`, `input_data`, `busy` and `button_pulse` go to 0 without waiting for a clock edge. After reset release with the button still held, no capture occurs until that press has been debounced as a new press.
